// File: rtl/tt_game_pkg.sv
// Shared constants for the Tiny Tapeout game: clock rate, debounce window
// and the layout of the ui_in pin fields.
package tt_game_pkg;

  localparam int unsigned CLK_HZ      = 20_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  // Stable cycles needed before an input change is accepted (20 ms at 20 MHz)
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Largest window the debounce counter is meant to support
  localparam int unsigned DEBOUNCE_CYCLES_MAX = (1 << 24) - 1;

  // Field positions and widths inside ui_in
  localparam int unsigned BTN_LSB = 4;
  localparam int unsigned BTN_W   = 4;
  localparam int unsigned DSW_LSB = 0;
  localparam int unsigned DSW_W   = 4;
  localparam int unsigned UI_W    = BTN_W + DSW_W;

  // ui_in viewed as its two fields: buttons in the upper nibble, DIP switches below
  typedef struct packed {
    logic [BTN_W-1:0] btn;
    logic [DSW_W-1:0] dsw;
  } ui_fields_t;

  // Counter width able to hold 0 .. cycles without wrapping
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-channel input conditioner: two-flop synchroniser, stability counter
// and optional press/release pulse registers.
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN (builds rise_out/fall_out registers;
// when undefined both pulses are tied low).
module debounce_bit
  import tt_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int unsigned CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             accept_c;

  // Synchroniser: plain flop-to-flop path, nothing in between
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  // Stability counter: any agreeing sample restarts the window from zero
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    accept_c = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept_c = 1'b1;
      level_d  = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_out = level_q;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;
  logic rise_d;
  logic fall_d;

  // Pulse decode aligned with the cycle the level is accepted
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (accept_c) begin
      rise_d = s2_q;
      fall_d = ~s2_q;
    end
  end

  // Pulse registers: high for exactly the cycle level_out changes
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_out = rise_q;
  assign fall_out = fall_q;
`else
  assign rise_out = 1'b0;
  assign fall_out = 1'b0;
`endif

endmodule

// File: rtl/input_debounce.sv
// Input conditioning between ui_in pins and the game FSM: one independent
// synchronise/debounce/edge-detect channel per input bit.
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN (press/release pulses;
// when undefined rise_out/fall_out read as zero, level_out is unchanged).
module input_debounce
  import tt_game_pkg::*;
#(
  parameter int unsigned WIDTH           = UI_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  // One conditioner per channel; channels never interact
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (raw_in[i]),
      .level_out(level_out[i]),
      .rise_out (rise_out[i]),
      .fall_out (fall_out[i])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce with a 4-cycle window. The reference model decides
// each edge from the raw sample history: a channel flips when the last
// DEBOUNCE_CYCLES synchronised samples all disagree with its current level.
module tb_input_debounce;

  localparam int unsigned W  = 8;
  localparam int unsigned DC = 4;
`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;

  int n_cmp;
  int n_bad;

  input_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in   (raw_in),
    .level_out(level_out),
    .rise_out (rise_out),
    .fall_out (fall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: hist[k] is the raw sample taken k edges ago (index 0 = this edge)
  logic [W-1:0] hist [0:DC+1];
  logic [W-1:0] m_level;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] m_dis;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= int'(DC) + 1; k++) hist[k] = '0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_valid = 1'b1;
    end else begin
      for (int k = int'(DC) + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw_in;
      m_dis = '1;
      for (int k = 2; k <= int'(DC) + 1; k++) m_dis &= (hist[k] ^ m_level);
      m_level = m_level ^ m_dis;
      m_rise  = EDGE_EN ? (m_dis & m_level)  : '0;
      m_fall  = EDGE_EN ? (m_dis & ~m_level) : '0;
    end
  end

  // Per-cycle comparison against the model, plus bit-0 activity for the glitch test
  logic [2:0] b0_seen;
  initial b0_seen = '0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("level_out", level_out, m_level);
      check("rise_out",  rise_out,  m_rise);
      check("fall_out",  fall_out,  m_fall);
      b0_seen = b0_seen | {level_out[0], rise_out[0], fall_out[0]};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] e_pulse;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    raw_in = 8'hFF;
    e_pulse = EDGE_EN ? 8'hFF : 8'h00;

    // 1: reset with all inputs high, then release
    tick(2);
    check("t1_rst_level", level_out, 8'h00);
    check("t1_rst_rise",  rise_out,  8'h00);
    reset = 1'b0;
    tick(5);
    check("t1_level_early", level_out, 8'h00);
    tick(1);
    check("t1_level", level_out, 8'hFF);
    check("t1_rise",  rise_out,  e_pulse);
    tick(1);
    check("t1_rise_off", rise_out, 8'h00);
    raw_in = 8'h00;
    tick(10);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    // 2: clean press and release on bit 7
    raw_in = 8'h80;
    tick(5);
    check("t2_level_early", level_out, 8'h00);
    tick(1);
    check("t2_level", level_out, 8'h80);
    check("t2_rise",  rise_out,  e_pulse & 8'h80);
    tick(1);
    check("t2_rise_off", rise_out, 8'h00);
    raw_in = 8'h00;
    tick(5);
    check("t2_hold", level_out, 8'h80);
    tick(1);
    check("t2_fall",     fall_out,  e_pulse & 8'h80);
    check("t2_level_lo", level_out, 8'h00);
    tick(3);

    // 3: bounce on bit 4 then settle high
    raw_in = 8'h10; tick(1);
    raw_in = 8'h00; tick(1);
    raw_in = 8'h10; tick(1);
    raw_in = 8'h00; tick(1);
    raw_in = 8'h10;
    tick(5);
    check("t3_level_early", level_out, 8'h00);
    tick(1);
    check("t3_level", level_out, 8'h10);
    tick(2);

    // 4: 3-cycle glitch on bit 0 must never reach the outputs
    b0_seen = '0;
    raw_in = 8'h11; tick(3);
    raw_in = 8'h10; tick(10);
    check("t4_b0_activity", {5'd0, b0_seen}, 8'h00);

    // 5: reset in the middle of a count on bit 5
    raw_in = 8'h20; tick(3);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    tick(5);
    check("t5_level_early", level_out, 8'h00);
    tick(1);
    check("t5_level", level_out, 8'h20);
    check("t5_rise",  rise_out,  e_pulse & 8'h20);
    tick(3);

    // Several channels changing together, checked by the model
    raw_in = 8'h0F; tick(8);
    raw_in = 8'hA5; tick(8);
    check("multi_level", level_out, 8'hA5);
    raw_in = 8'h5A; tick(2);
    raw_in = 8'hA5; tick(8);
    check("multi_level_held", level_out, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Input conditioning stage between the Tiny Tapeout `ui_in` pins and the game state machine. It synchronises, debounces and edge-detects the eight raw inputs: buttons on `ui_in[7:4]`, DIP switches on `ui_in[3:0]`. The game logic consumes only clean, stable levels and single-cycle press/release pulses, never raw pins.

## Interface
- `WIDTH`, 8: number of independent input channels.
- `DEBOUNCE_CYCLES`, 400_000: consecutive stable cycles required to accept a change (20 ms at 20 MHz). Legal range is 1 to 2^24−1.
- `clk` input 1: system clock; one clock domain.
- `reset` input 1: synchronous, active-high reset.
- `raw_in` input WIDTH: asynchronous pin levels.
- `level_out` output WIDTH: debounced level per channel.
- `rise_out` output WIDTH: one-cycle pulse when `level_out[i]` goes 0→1.
- `fall_out` output WIDTH: one-cycle pulse when `level_out[i]` goes 1→0.

## Operation
- Each channel is independent; the logic below applies per bit.
- Two-flop synchroniser: `raw_in` → `s1` → `s2`. No logic between the flops.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, saturation impossible by construction. Evaluated in priority order:
  - If `s2 == level_out`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level_out <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Any disagreement shorter than `DEBOUNCE_CYCLES` cycles leaves `level_out` unchanged. A single agreeing sample restarts the count from 0, with no partial credit.
- `rise_out`/`fall_out` are registered. Each asserts in the same cycle `level_out` takes its new value, for exactly one cycle.
- Several channels may change in the same cycle; each pulses independently.
- Polarity is not inverted. A button that is high when pressed produces `rise_out` on press.

## Timing
- Reset values: `s1`, `s2`, `cnt`, `level_out`, `rise_out`, `fall_out` all 0.
- Reset is synchronous. It takes effect at the first clock edge with `reset`=1 and overrides any in-progress count.
- After reset deasserts, a channel held at 1 reaches `level_out`=1 and pulses `rise_out`. No suppression of the post-reset edge.
- Latency: if `raw_in` changes before edge E0 and then stays stable, `level_out` and the pulse appear after edge E0+`DEBOUNCE_CYCLES`+1, i.e. `DEBOUNCE_CYCLES`+2 edges.
- With `DEBOUNCE_CYCLES`=1 the block is a pure synchroniser with edge detect; latency is 3 edges.
- Minimum spacing between successive `rise_out` pulses on one channel is 2×`DEBOUNCE_CYCLES` cycles.

## Configuration
- `INPUT_DEBOUNCE_EDGE_EN` defined: the edge-pulse registers are compiled in and `rise_out`/`fall_out` behave as specified above.
- `INPUT_DEBOUNCE_EDGE_EN` undefined: the edge registers are not built and `rise_out`/`fall_out` are tied to 0.
- The port list is identical in both builds. `level_out` timing is unaffected.

## Structure
- Shared package `tt_game_pkg` holds:
  - `CLK_HZ` = 20_000_000.
  - `DEBOUNCE_MS` = 20.
  - Derived `DEBOUNCE_CYCLES_DEFAULT`.
  - `BTN_LSB` = 4 and `DSW_LSB` = 0, the channel field positions in `ui_in`.
- One sub-module, `debounce_bit`: synchroniser, counter and edge registers for a single channel. The top-level block instantiates it `WIDTH` times with a generate loop.
- No other hierarchy.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `INPUT_DEBOUNCE_EDGE_EN` defined unless noted.
1. Reset with `raw_in`=8'hFF, then release reset → all outputs 0 during reset. `level_out`=8'hFF and `rise_out`=8'hFF for one cycle, 6 edges after the first post-reset edge.
2. Clean press on bit 7: `raw_in` 0→1 held → `level_out[7]` rises 6 edges later, `rise_out[7]` is high exactly one cycle, other bits stay 0. Release → `fall_out[7]` pulses 6 edges later.
3. Bounce: bit 4 toggles 1,0,1,0 for one cycle each, then holds 1 → no output change during the bounce. `level_out[4]`=1 six edges after the final transition.
4. Glitch: bit 0 high for 3 cycles then low → `level_out[0]`, `rise_out[0]` and `fall_out[0]` never assert.
5. Reset mid-count: bit 5 high for 3 cycles, `reset` asserted for one cycle, bit 5 held high → `cnt` cleared. `level_out[5]` rises 6 edges after reset deasserts, not earlier.
6. Build without `INPUT_DEBOUNCE_EDGE_EN`, repeat scenario 2 → identical `level_out` timing. `rise_out`/`fall_out` remain 8'h00 throughout.
